// File: rtl/fb_fetch_arbiter.sv
// fb_fetch_arbiter: shares one single-port framebuffer RAM between the display
// fetch path and a host write port. Display reads always win. Each fetched
// 16-bit word is shifted out MSB-first as 1bpp pixels, aligned with pos_x/pos_y.
// Host stall cycles are counted per frame.
`timescale 1ns/1ps
module fb_fetch_arbiter #(
  parameter int H_DISPLAY      = 640,
  parameter int V_DISPLAY      = 480,
  parameter int H_TOTAL        = 800,
  parameter int V_TOTAL        = 525,
  parameter int WORDS_PER_LINE = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        video_on,
  input  logic        host_valid,
  input  logic [14:0] host_addr,
  input  logic [15:0] host_data,
  output logic        host_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        pixel,
  output logic        frame_start,
  output logic [15:0] host_stall_cnt
);

  localparam logic [9:0]  MID_LIMIT_X  = 10'(H_DISPLAY - 16);
  localparam logic [9:0]  LINE_FETCH_X = 10'(H_TOTAL - 2);
  localparam logic [9:0]  LAST_X       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  LAST_Y       = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VIS_LINES    = 10'(V_DISPLAY);
  localparam logic [14:0] WPL          = 15'(WORDS_PER_LINE);
  localparam logic [14:0] FB_WORDS     = 15'(V_DISPLAY * WORDS_PER_LINE);

  logic [9:0]  next_row;
  logic        mid_fetch;
  logic        line_fetch;
  logic        fetch;
  logic [14:0] fetch_addr;
  logic        frame_end;

  logic        rd_pending_q, rd_pending_d;
  logic [15:0] shift_q, shift_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Decode the two fetch points and form the display read address.
  always_comb begin
    next_row   = (pos_y == LAST_Y) ? 10'd0 : pos_y + 10'd1;
    mid_fetch  = video_on && (pos_x[3:0] == 4'd14) && (pos_x < MID_LIMIT_X);
    line_fetch = (pos_x == LINE_FETCH_X) && (next_row < VIS_LINES);
    // Reset masks fetches so nothing is launched or left pending while held.
    fetch      = reset && (mid_fetch || line_fetch);
    if (mid_fetch) begin
      fetch_addr = 15'(pos_y) * WPL + 15'(pos_x[9:4]) + 15'd1;
    end else begin
      fetch_addr = 15'(next_row) * WPL;
    end
  end

  // RAM port arbitration: the display fetch wins, otherwise the host owns the port.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    host_ready = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (fetch) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr;
    end else if (reset) begin
      host_ready = 1'b1;
      if (host_valid) begin
        mem_en    = 1'b1;
        // Writes beyond the visible framebuffer are accepted but dropped.
        mem_we    = (host_addr < FB_WORDS);
        mem_addr  = host_addr;
        mem_wdata = host_data;
      end
    end
  end

  // Next state of the read pipeline, pixel shifter, frame marker and stall counter.
  always_comb begin
    frame_end     = (pos_x == LAST_X) && (pos_y == LAST_Y);
    rd_pending_d  = fetch;
    shift_d       = shift_q;
    if (rd_pending_q) begin
      shift_d = mem_rdata;
    end else if (video_on) begin
      shift_d = {shift_q[14:0], 1'b0};
    end
    frame_start_d = frame_end;
    stall_cnt_d   = stall_cnt_q;
    if (frame_end) begin
      stall_cnt_d = '0;
    end else if (host_valid && fetch && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers; reset discards any in-flight read and blanks the shifter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pending_q  <= 1'b0;
      shift_q       <= '0;
      frame_start_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      rd_pending_q  <= rd_pending_d;
      shift_q       <= shift_d;
      frame_start_q <= frame_start_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign pixel          = video_on & shift_q[15];
  assign frame_start    = frame_start_q;
  assign host_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fb_fetch_arbiter.sv
// Bench for fb_fetch_arbiter: reset checks, a table of single-cycle arbitration
// vectors, line sweeps against a rule-level reference model with a RAM model and
// write scoreboard, a mid-line reset, and stall counter saturation/clear.
`timescale 1ns/1ps
module tb_fb_fetch_arbiter;
  localparam int VD = 480;
  localparam int WPL = 40;
  localparam int FB_WORDS = VD * WPL;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pos_x, pos_y;
  logic        video_on, host_valid;
  logic [14:0] host_addr;
  logic [15:0] host_data;
  logic        host_ready, mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        pixel, frame_start;
  logic [15:0] host_stall_cnt;

  fb_fetch_arbiter #(
    .H_DISPLAY(640), .V_DISPLAY(480), .H_TOTAL(800), .V_TOTAL(525), .WORDS_PER_LINE(40)
  ) dut (
    .clk(clk), .reset(reset), .pos_x(pos_x), .pos_y(pos_y), .video_on(video_on),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pixel(pixel),
    .frame_start(frame_start), .host_stall_cnt(host_stall_cnt)
  );

  always #5 clk = ~clk;

  // Single-port RAM model with one-cycle read latency and a bench preload port.
  logic [15:0] ram [0:32767];
  logic        pre_we = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [15:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    else if (mem_en) mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] exp_ram [0:32767];
  int primed_row = -1;
  int model_cnt  = 0;
  bit fs_pend    = 0;
  bit last_acc   = 0;
  int acc_q[$];
  int stall_q[$];
  int stall_row  = -1;
  logic pix_cap [0:3][0:799];
  int cur_ha = 4000;
  int cur_hd = 0;

  typedef struct {
    int x; int y; bit von; bit hv; int ha; int hd;
    bit e_ready; bit e_en; bit e_we; int e_addr;
  } vec_t;
  vec_t vt [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input int x, input int y, input bit von, input bit hv,
                       input int ha, input int hd, input bit rn);
    @(posedge clk);
    #1;
    pos_x = 10'(x); pos_y = 10'(y); video_on = von; host_valid = hv;
    host_addr = 15'(ha); host_data = 16'(hd); reset = rn;
    @(negedge clk);
  endtask

  task automatic preload(input int a, input int d);
    @(posedge clk);
    #1;
    pre_we = 1'b1; pre_addr = 15'(a); pre_data = 16'(d);
    exp_ram[a] = 16'(d);
  endtask

  // One cycle at (x,y), checked against the rule-level model.
  task automatic apply_chk(input int x, input int y, input bit hv, input int ha,
                           input int hd, input bit rn);
    bit von, mid, lst, fetch, e_ready, acc, e_en, e_we;
    int nrow, e_addr;
    logic [15:0] w;
    string tag;
    von     = (x < 640) && (y < VD);
    nrow    = (y == 524) ? 0 : y + 1;
    mid     = von && (x % 16 == 14) && (x < 624);
    lst     = (x == 798) && (nrow < VD);
    fetch   = rn && (mid || lst);
    e_ready = rn && !fetch;
    acc     = hv && e_ready;
    e_en    = fetch || acc;
    e_we    = acc && (ha < FB_WORDS);
    e_addr  = fetch ? (mid ? y * WPL + x / 16 + 1 : nrow * WPL) : (acc ? ha : 0);
    apply(x, y, von, hv, ha, hd, rn);
    tag = $sformatf("@x%0d,y%0d", x, y);
    check({"host_ready", tag}, 32'(host_ready), 32'(e_ready));
    check({"mem_en", tag}, 32'(mem_en), 32'(e_en));
    check({"mem_we", tag}, 32'(mem_we), 32'(e_we));
    check({"mem_addr", tag}, 32'(mem_addr), 32'(e_addr));
    if (acc) check({"mem_wdata", tag}, 32'(mem_wdata), 32'(hd & 16'hFFFF));
    check({"frame_start", tag}, 32'(frame_start), 32'(rn && fs_pend));
    check({"stall_cnt", tag}, 32'(host_stall_cnt), rn ? 32'(model_cnt) : 32'd0);
    if (!rn || !von) begin
      check({"pixel", tag}, 32'(pixel), 32'd0);
    end else if (primed_row == y) begin
      w = exp_ram[y * WPL + x / 16];
      check({"pixel", tag}, 32'(pixel), 32'(w[15 - x % 16]));
    end
    if (y < 4) pix_cap[y][x] = pixel;
    if (y == stall_row && !host_ready) stall_q.push_back(x);
    last_acc = acc;
    if (!rn) begin
      model_cnt = 0; fs_pend = 0; primed_row = -1;
    end else begin
      if (x == 799 && y == 524) begin
        fs_pend = 1; model_cnt = 0;
      end else begin
        fs_pend = 0;
        if (hv && fetch && model_cnt < 65535) model_cnt++;
      end
      if (lst) primed_row = nrow;
      if (e_we) begin
        exp_ram[ha] = 16'(hd);
        acc_q.push_back(ha);
      end
    end
  endtask

  // Sweep x0..x1 of line y. mode 0: idle host, 1: continuous held requests, 2: random.
  task automatic sweep(input int y, input int x0, input int x1, input int mode,
                       input int rlo, input int rhi);
    bit hv; int ha, hd;
    for (int x = x0; x <= x1; x++) begin
      hv = 0; ha = 0; hd = 0;
      if (mode == 1) begin
        hv = 1; ha = cur_ha; hd = cur_hd;
      end else if (mode == 2) begin
        hv = bit'($urandom_range(1));
        ha = ($urandom_range(3) == 0) ? 19200 + $urandom_range(99) : 4000 + $urandom_range(13999);
        hd = $urandom_range(65535);
      end
      apply_chk(x, y, hv, ha, hd, !(x >= rlo && x <= rhi));
      if (mode == 1 && last_acc) begin
        cur_ha = (cur_ha >= 17999) ? 4000 : cur_ha + 1;
        cur_hd = $urandom_range(65535);
      end
    end
  endtask

  initial begin
    logic [3:0]  p0;
    logic [15:0] w81;
    int ones;
    reset = 1'b0; pos_x = '0; pos_y = '0; video_on = 1'b0;
    host_valid = 1'b0; host_addr = '0; host_data = '0;

    // Reset: everything quiet even at fetch points with a pending host write.
    apply(798, 524, 0, 1, 5, 16'h1234, 0);
    check("rst_host_ready", 32'(host_ready), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_pixel", 32'(pixel), 0);
    check("rst_stall_cnt", 32'(host_stall_cnt), 0);
    apply(14, 2, 1, 1, 19199, 16'hBEEF, 0);
    check("rst_mid_host_ready", 32'(host_ready), 0);
    check("rst_mid_mem_en", 32'(mem_en), 0);
    apply(799, 524, 0, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0);
    check("rst_frame_start", 32'(frame_start), 0);

    // Single-cycle arbitration vectors.
    vt[0]  = '{798, 524, 0, 1, 5,     16'h1111, 0, 1, 0, 0};
    vt[1]  = '{14,  2,   1, 1, 5,     16'h2222, 0, 1, 0, 81};
    vt[2]  = '{622, 479, 1, 0, 0,     0,        0, 1, 0, 19199};
    vt[3]  = '{638, 2,   1, 1, 100,   16'h3333, 1, 1, 1, 100};
    vt[4]  = '{798, 478, 0, 0, 0,     0,        0, 1, 0, 19160};
    vt[5]  = '{798, 479, 0, 1, 9,     16'h4444, 1, 1, 1, 9};
    vt[6]  = '{14,  2,   0, 0, 0,     0,        1, 0, 0, 0};
    vt[7]  = '{13,  2,   1, 1, 19200, 16'h5555, 1, 1, 0, 19200};
    vt[8]  = '{13,  2,   1, 1, 19199, 16'h6666, 1, 1, 1, 19199};
    vt[9]  = '{799, 524, 0, 1, 7,     16'h7777, 1, 1, 1, 7};
    vt[10] = '{30,  0,   1, 1, 8,     16'h8888, 0, 1, 0, 2};
    vt[11] = '{798, 523, 0, 0, 0,     0,        1, 0, 0, 0};
    vt[12] = '{606, 10,  1, 0, 0,     0,        0, 1, 0, 438};
    vt[13] = '{15,  0,   1, 0, 0,     0,        1, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      apply(vt[i].x, vt[i].y, vt[i].von, vt[i].hv, vt[i].ha, vt[i].hd, 1);
      check($sformatf("vec%0d_host_ready", i), 32'(host_ready), 32'(vt[i].e_ready));
      check($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(vt[i].e_en));
      check($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vt[i].e_we));
      check($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
      if (vt[i].e_we) check($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(vt[i].hd));
    end

    // Preload visible rows 0..3 with the DUT held in reset.
    reset = 1'b0;
    for (int a = 0; a < 4 * WPL; a++) begin
      preload(a, (a == 0) ? 16'hA000 : (a == 81) ? 16'h8001 : $urandom_range(65535));
    end
    @(posedge clk);
    #1;
    pre_we = 1'b0;

    // Frame wrap into line 0, then full lines with continuous and random host traffic.
    apply_chk(0, 0, 0, 0, 0, 0);
    sweep(524, 790, 799, 2, -1, -1);
    stall_row = 0;
    sweep(0, 0, 799, 1, -1, -1);
    stall_row = -1;
    sweep(1, 0, 799, 2, -1, -1);
    sweep(2, 0, 799, 1, -1, -1);
    sweep(3, 0, 99, 2, -1, -1);

    p0 = 4'b1010;
    for (int i = 0; i < 4; i++) check($sformatf("line0_pixel%0d", i), 32'(pix_cap[0][i]), 32'(p0[3 - i]));
    w81 = 16'h8001;
    for (int i = 0; i < 16; i++) check($sformatf("line2_pixel%0d", 16 + i), 32'(pix_cap[2][16 + i]), 32'(w81[15 - i]));
    check("stall_positions_count", 32'(stall_q.size()), 40);
    for (int i = 0; i < stall_q.size() && i < 40; i++) begin
      check($sformatf("stall_pos%0d", i), 32'(stall_q[i]), (i < 39) ? 32'(14 + 16 * i) : 32'd798);
    end

    // Reset during the read that follows the x=14 fetch, held to the line-start fetch.
    sweep(1, 0, 799, 2, -1, -1);
    sweep(2, 0, 799, 2, 15, 797);
    ones = 0;
    for (int x = 15; x < 640; x++) if (pix_cap[2][x] !== 1'b0) ones++;
    check("reset_line_pixels_nonzero", 32'(ones), 0);
    sweep(3, 0, 799, 2, -1, -1);

    // Every accepted in-range write must have reached the RAM with its data.
    apply(5, 300, 0, 0, 0, 0, 1);
    apply(6, 300, 0, 0, 0, 0, 1);
    for (int i = 0; i < acc_q.size(); i++) begin
      check($sformatf("ram_word_%0d", acc_q[i]), 32'(ram[acc_q[i]]), 32'(exp_ram[acc_q[i]]));
    end

    // Stall counter saturation, then clear on the frame_start edge.
    apply(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) apply(798, 0, 0, 1, 20, 0, 1);
    apply(798, 0, 0, 1, 20, 0, 1);
    check("stall_cnt_fffe", 32'(host_stall_cnt), 32'hFFFE);
    apply(798, 0, 0, 1, 20, 0, 1);
    check("stall_cnt_ffff", 32'(host_stall_cnt), 32'hFFFF);
    for (int i = 0; i < 3; i++) apply(798, 0, 0, 1, 20, 0, 1);
    check("stall_cnt_saturated", 32'(host_stall_cnt), 32'hFFFF);
    check("stall_host_ready", 32'(host_ready), 0);
    apply(799, 524, 0, 1, 20, 0, 1);
    check("stall_cnt_before_clear", 32'(host_stall_cnt), 32'hFFFF);
    check("frame_start_before", 32'(frame_start), 0);
    apply(0, 0, 1, 0, 0, 0, 1);
    check("frame_start_pulse", 32'(frame_start), 1);
    check("stall_cnt_cleared", 32'(host_stall_cnt), 0);
    apply(1, 0, 1, 0, 0, 0, 1);
    check("frame_start_one_cycle", 32'(frame_start), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
